bs_request_sequencer: RTL and testbench

BS_REQUEST_SEQUENCER -- requirements
Module: bs_request_sequencer

---
 rtl/bs_request_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_bs_request_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bs_request_sequencer.sv
// Request sequencer for a fixed-latency option-pricing core.
// Requests are queued in a small FIFO, screened for non-positive operands,
// issued one at a time to the core, and the result is held until accepted.
module bs_request_sequencer #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 4,
   parameter int LATENCY = 40,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [WIDTH-1:0] in_spot,
   input  logic [WIDTH-1:0] in_strike,
   input  logic [WIDTH-1:0] in_timetm,
   input  logic [WIDTH-1:0] in_sigma,
   input  logic [WIDTH-1:0] in_rate,
   input  logic             in_otype,
   output logic             core_start,
   output logic [WIDTH-1:0] core_spot,
   output logic [WIDTH-1:0] core_strike,
   output logic [WIDTH-1:0] core_timetm,
   output logic [WIDTH-1:0] core_sigma,
   output logic [WIDTH-1:0] core_rate,
   output logic             core_otype,
   input  logic [WIDTH-1:0] core_price,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [WIDTH-1:0] out_price,
   output logic             out_err,
   output logic             busy
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   // FIFO entry layout: {tag, spot, strike, timetm, sigma, rate, otype}
   localparam int O_OT   = 0;
   localparam int O_RATE = 1;
   localparam int O_SIG  = 1 + WIDTH;
   localparam int O_TM   = 1 + 2 * WIDTH;
   localparam int O_STK  = 1 + 3 * WIDTH;
   localparam int O_SPOT = 1 + 4 * WIDTH;
   localparam int O_TAG  = 1 + 5 * WIDTH;
   localparam int EW     = 1 + 5 * WIDTH + TAG_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t state, state_next;

   logic [EW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             ready_en;
   logic [LW-1:0]    lat_cnt;
   logic             push, pop, reject;
   logic [EW-1:0]    head;

   logic [WIDTH-1:0] hold_spot, hold_strike, hold_timetm, hold_sigma, hold_rate;
   logic             hold_otype;

   assign in_ready = ready_en && (count != CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (state == S_IDLE) && (count != '0);
   assign head     = mem[rd_ptr];

   // A value is non-positive if its sign bit is set or it is exactly zero.
   assign reject = head[O_SPOT + WIDTH - 1] || (head[O_SPOT +: WIDTH] == '0) ||
                   head[O_STK  + WIDTH - 1] || (head[O_STK  +: WIDTH] == '0) ||
                   head[O_TM   + WIDTH - 1] || (head[O_TM   +: WIDTH] == '0) ||
                   head[O_SIG  + WIDTH - 1] || (head[O_SIG  +: WIDTH] == '0);

   assign core_spot   = hold_spot;
   assign core_strike = hold_strike;
   assign core_timetm = hold_timetm;
   assign core_sigma  = hold_sigma;
   assign core_rate   = hold_rate;
   assign core_otype  = hold_otype;
   assign busy        = (state != S_IDLE) || (count != '0);

   // FIFO storage write; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_tag, in_spot, in_strike, in_timetm, in_sigma, in_rate, in_otype};
      end
   end

   // FIFO pointers, occupancy and the post-reset ready enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   // FSM next-state and strobe outputs.
   always_comb begin
      state_next = state;
      core_start = 1'b0;
      out_valid  = 1'b0;
      unique case (state)
         S_IDLE:  if (pop) state_next = reject ? S_OUT : S_ISSUE;
         S_ISSUE: begin
            core_start = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT:  if (lat_cnt == '0) state_next = S_OUT;
         S_OUT:   begin
            out_valid = 1'b1;
            if (out_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Operand holding registers, latency counter and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_spot   <= '0;
         hold_strike <= '0;
         hold_timetm <= '0;
         hold_sigma  <= '0;
         hold_rate   <= '0;
         hold_otype  <= 1'b0;
         lat_cnt     <= '0;
         out_tag     <= '0;
         out_price   <= '0;
         out_err     <= 1'b0;
      end else begin
         if (pop) begin
            hold_spot   <= head[O_SPOT +: WIDTH];
            hold_strike <= head[O_STK  +: WIDTH];
            hold_timetm <= head[O_TM   +: WIDTH];
            hold_sigma  <= head[O_SIG  +: WIDTH];
            hold_rate   <= head[O_RATE +: WIDTH];
            hold_otype  <= head[O_OT];
            out_tag     <= head[O_TAG  +: TAG_W];
            if (reject) begin
               out_price <= '0;
               out_err   <= 1'b1;
            end
         end
         if (state == S_ISSUE) begin
            lat_cnt <= LW'(LATENCY - 1);
         end else if (state == S_WAIT) begin
            if (lat_cnt == '0) begin
               out_price <= core_price;
               out_err   <= 1'b0;
            end else begin
               lat_cnt <= lat_cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bs_request_sequencer.sv
// Bench for bs_request_sequencer: a fixed-latency core model, a scoreboard of
// expected results built from accepted requests, and directed scenarios.
module tb_bs_request_sequencer;

   localparam int W = 32;
   localparam int D = 4;
   localparam int L = 40;
   localparam int T = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, in_otype;
   logic [T-1:0] in_tag;
   logic [W-1:0] in_spot, in_strike, in_timetm, in_sigma, in_rate;
   logic         core_start, core_otype;
   logic [W-1:0] core_spot, core_strike, core_timetm, core_sigma, core_rate, core_price;
   logic         out_valid, out_ready, out_err, busy;
   logic [T-1:0] out_tag;
   logic [W-1:0] out_price;

   bs_request_sequencer #(.WIDTH(W), .DEPTH(D), .LATENCY(L), .TAG_W(T)) dut (
      .clk(clk), .reset(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
      .in_spot(in_spot), .in_strike(in_strike), .in_timetm(in_timetm),
      .in_sigma(in_sigma), .in_rate(in_rate), .in_otype(in_otype),
      .core_start(core_start), .core_spot(core_spot), .core_strike(core_strike),
      .core_timetm(core_timetm), .core_sigma(core_sigma), .core_rate(core_rate),
      .core_otype(core_otype), .core_price(core_price),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .out_price(out_price), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] price_fn(input logic [31:0] s, k, tm, v, r, input logic ot);
      logic [31:0] d;
      d = ot ? (k - s) : (s - k);
      return d + v + r + (tm >> 4);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Pricing-core model: price is valid only in the cycle LATENCY cycles after start.
   int ccnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)            ccnt <= 0;
      else if (core_start)   ccnt <= 1;
      else if (ccnt != 0)    ccnt <= ccnt + 1;
   end
   assign core_price = (ccnt == L) ?
      price_fn(core_spot, core_strike, core_timetm, core_sigma, core_rate, core_otype) :
      32'hBAD0_BAD0;

   typedef struct {
      logic [T-1:0] tag;
      logic [W-1:0] price;
      logic         err;
   } exp_t;
   exp_t exp_q[$];

   int           n_starts  = 0;
   int           start_cyc = 0;
   int           n_out     = 0;
   logic         prev_start = 1'b0;
   logic         held       = 1'b0;
   logic [T-1:0] h_tag;
   logic [W-1:0] h_price;
   logic         h_err;

   // Monitor: scoreboard push/pop, start-pulse rules and OUT hold stability.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_start = 1'b0;
         held       = 1'b0;
      end else begin
         exp_t e;
         if (core_start) begin
            n_starts++;
            start_cyc = cyc;
            check("start_consecutive", 32'(prev_start), 32'd0);
            check("start_during_out", 32'(out_valid), 32'd0);
         end
         prev_start = core_start;
         if (held && out_valid) begin
            check("hold_tag", 32'(out_tag), 32'(h_tag));
            check("hold_price", out_price, h_price);
            check("hold_err", 32'(out_err), 32'(h_err));
         end
         if (in_valid && in_ready) begin
            e.tag = in_tag;
            e.err = ($signed(in_spot) <= 0) || ($signed(in_strike) <= 0) ||
                    ($signed(in_timetm) <= 0) || ($signed(in_sigma) <= 0);
            e.price = e.err ? 32'd0 :
                      price_fn(in_spot, in_strike, in_timetm, in_sigma, in_rate, in_otype);
            exp_q.push_back(e);
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               check("sb_unexpected_result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("sb_tag", 32'(out_tag), 32'(e.tag));
               check("sb_price", out_price, e.price);
               check("sb_err", 32'(out_err), 32'(e.err));
            end
         end
         held    = out_valid && !out_ready;
         h_tag   = out_tag;
         h_price = out_price;
         h_err   = out_err;
      end
   end

   // Drive one request and return the cycle number of its accepting edge.
   task automatic send(input logic [T-1:0] t, input logic [W-1:0] s, k, tm, v, r,
                       input logic ot, output int pc);
      bit ok;
      in_valid  = 1'b1;
      in_tag    = t;
      in_spot   = s;
      in_strike = k;
      in_timetm = tm;
      in_sigma  = v;
      in_rate   = r;
      in_otype  = ot;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      pc = cyc;
      if (!ok) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_out(output int c);
      bit ok;
      ok = 1'b0;
      c  = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            c  = cyc;
            break;
         end
      end
      if (!ok) check("out_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!busy && !out_valid && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string p);
      check({p, "_in_ready"},   32'(in_ready),   32'd0);
      check({p, "_out_valid"},  32'(out_valid),  32'd0);
      check({p, "_core_start"}, 32'(core_start), 32'd0);
      check({p, "_busy"},       32'(busy),       32'd0);
      check({p, "_out_tag"},    32'(out_tag),    32'd0);
      check({p, "_out_price"},  out_price,       32'd0);
      check({p, "_out_err"},    32'(out_err),    32'd0);
      check({p, "_core_spot"},  core_spot,       32'd0);
      check({p, "_core_sigma"}, core_sigma,      32'd0);
      check({p, "_count"},      32'(dut.count),  32'd0);
   endtask

   int pc, oc, s0, n0, dummy_pc;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_tag = '0; in_otype = 1'b0; out_ready = 1'b1;
      in_spot = '0; in_strike = '0; in_timetm = '0; in_sigma = '0; in_rate = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("ready_after_edge", 32'(in_ready), 32'd1);

      // Valid call request: start 1 edge after push, result LATENCY+2 edges after.
      s0 = n_starts;
      send(4'd3, 32'h0064_0000, 32'h005F_0000, 32'h0001_0000, 32'h0000_3333, 32'h0000_0CCD,
           1'b0, pc);
      wait_out(oc);
      check("valid_latency", 32'(oc - pc), 32'(L + 2));
      check("valid_out_tag", 32'(out_tag), 32'd3);
      check("valid_out_price", out_price, 32'h0005_4000 + 32'h0000_1000);
      check("valid_out_err", 32'(out_err), 32'd0);
      wait_idle();
      check("valid_start_count", 32'(n_starts - s0), 32'd1);
      check("valid_start_offset", 32'(start_cyc - pc), 32'd1);

      // Rejected request: sigma = 0.
      s0 = n_starts;
      send(4'd5, 32'h0064_0000, 32'h005F_0000, 32'h0001_0000, 32'h0, 32'h0000_0CCD, 1'b1, pc);
      wait_out(oc);
      check("reject_latency", 32'(oc - pc), 32'd1);
      check("reject_out_price", out_price, 32'd0);
      check("reject_out_err", 32'(out_err), 32'd1);
      wait_idle();
      check("reject_no_start", 32'(n_starts - s0), 32'd0);

      // Back-pressure: fill the FIFO while the consumer stalls.
      out_ready = 1'b0;
      n0 = n_out;
      for (int j = 0; j < 5; j++) begin
         send(T'(6 + j), (32'(50 + j)) << 16, 32'h0030_0000, 32'h0002_0000, 32'h0000_4000,
              32'h0000_0800, 1'(j), dummy_pc);
      end
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(dut.count), 32'(D));
      fork
         send(4'd11, 32'h0040_0000, 32'h0041_0000, 32'h0000_8000, 32'h0000_2000,
              32'h0000_0400, 1'b1, dummy_pc);
      join_none
      wait_out(oc);
      s0 = n_starts;
      repeat (10) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      check("stall_no_start", 32'(n_starts - s0), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (n_starts != s0) break;
      end
      check("release_issues", 32'(n_starts - s0), 32'd1);
      wait_idle();
      check("stall_results", 32'(n_out - n0), 32'd6);

      // Reset in the middle of WAIT with two entries queued.
      for (int j = 0; j < 3; j++) begin
         send(T'(12 + j), 32'h0010_0000, 32'h0011_0000, 32'h0001_0000, 32'h0000_4000,
              32'h0, 1'b0, dummy_pc);
      end
      check("pre_reset_count", 32'(dut.count), 32'd2);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_reset_state("midrst");
      check("midrst_lat_cnt", 32'(dut.lat_cnt), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n0 = n_out;
      repeat (100) @(negedge clk);
      check("post_reset_no_result", 32'(n_out - n0), 32'd0);
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_count", 32'(dut.count), 32'd0);
      @(posedge clk);
      #1;

      // Simultaneous push/pop at count 2, then pointer wrap after 9 pushes.
      out_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         send(T'(1 + j), 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 1'b0,
              dummy_pc);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("pp_count_before", 32'(dut.count), 32'd2);
      @(posedge clk);
      #1;
      in_valid = 1'b1; in_tag = 4'd4; in_spot = 32'hFFFF_0000; in_strike = 32'h0001_0000;
      in_timetm = 32'h0001_0000; in_sigma = 32'h0000_1000; in_rate = 32'h0; in_otype = 1'b0;
      @(negedge clk);
      check("pp_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("pp_count_after", 32'(dut.count), 32'd2);
      check("pp_wr_ptr_wrap", 32'(dut.wr_ptr), 32'd0);
      wait_idle();
      for (int j = 0; j < 5; j++) begin
         send(T'(5 + j), 32'h0002_0000, 32'h0, 32'h0001_0000, 32'h0000_1000, 32'h0, 1'b1,
              dummy_pc);
      end
      wait_idle();
      check("wrap_wr_ptr", 32'(dut.wr_ptr), 32'd1);
      check("wrap_rd_ptr", 32'(dut.rd_ptr), 32'd1);
      check("wrap_count", 32'(dut.count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
